// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: question generator, answer-stability checker and scorer for the keypad quiz.
// Optional per-question timeout is compiled in when QUIZ_TIMEOUT_EN is defined.
module quiz_round_ctrl #(
    parameter int unsigned NUM_QUESTIONS  = 10,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned HOLD_CYCLES    = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start,
    input  logic [6:0] answer,
    output logic [6:0] operand_a,
    output logic [6:0] operand_b,
    output logic [6:0] score,
    output logic       correct,
    output logic       round_active,
    output logic       game_over,
    output logic [6:0] q_index
);

    localparam int unsigned StableW  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HoldW    = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [StableW-1:0] StableLast = StableW'(STABLE_CYCLES - 1);
    localparam logic [HoldW-1:0]   HoldLast   = HoldW'(HOLD_CYCLES - 1);
    localparam logic [6:0]         NumQ       = 7'(NUM_QUESTIONS);
    localparam logic [6:0]         ScoreMax   = 7'd99;
    localparam logic [7:0]         SumMax     = 8'd99;
    localparam logic [15:0]        LfsrSeed   = 16'hACE1;

    typedef enum logic [2:0] {
        StIdle,
        StNewQ,
        StWait,
        StHit,
        StHold,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               start_q, start_d;
    logic [6:0]         op_a_q, op_a_d;
    logic [6:0]         op_b_q, op_b_d;
    logic [6:0]         score_q, score_d;
    logic [6:0]         q_index_q, q_index_d;
    logic [StableW-1:0] stable_q, stable_d;
    logic [HoldW-1:0]   hold_q, hold_d;

`ifdef QUIZ_TIMEOUT_EN
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
    logic [TimeoutW-1:0] timeout_q, timeout_d;
`else
    logic [TimeoutW-1:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TimeoutW'(TIMEOUT_CYCLES);
`endif

    logic       start_rise;
    logic [7:0] cand_sum;
    logic [7:0] exp_sum;
    logic       answer_match;
    logic [6:0] score_inc;
    logic       stable_hit;
    logic       timeout_hit;

    assign start_rise   = start & ~start_q;
    assign cand_sum     = {1'b0, lfsr_q[6:0]} + {1'b0, lfsr_q[14:8]};
    // Sum never exceeds 99, so the scanner's "no entry" code 100 can never match.
    assign exp_sum      = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign answer_match = ({1'b0, answer} == exp_sum);
    assign score_inc    = (score_q >= ScoreMax) ? ScoreMax : score_q + 7'd1;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        start_d     = start;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        score_d     = score_q;
        q_index_d   = q_index_q;
        stable_d    = stable_q;
        hold_d      = hold_q;
        stable_hit  = 1'b0;
        timeout_hit = 1'b0;
`ifdef QUIZ_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif

        case (state_q)
            StIdle, StDone: begin
                if (start_rise) begin
                    score_d   = 7'd0;
                    q_index_d = 7'd0;
                    state_d   = StNewQ;
                end
            end

            StNewQ: begin
                if (cand_sum <= SumMax) begin
                    op_a_d    = lfsr_q[6:0];
                    op_b_d    = lfsr_q[14:8];
                    q_index_d = q_index_q + 7'd1;
                    stable_d  = '0;
`ifdef QUIZ_TIMEOUT_EN
                    timeout_d = '0;
`endif
                    state_d   = StWait;
                end
            end

            StWait: begin
                if (answer_match) begin
                    if (stable_q == StableLast) begin
                        stable_hit = 1'b1;
                    end else begin
                        stable_d = stable_q + StableW'(1);
                    end
                end else begin
                    stable_d = '0;
                end
`ifdef QUIZ_TIMEOUT_EN
                if (timeout_q == TimeoutLast) begin
                    timeout_hit = 1'b1;
                end else begin
                    timeout_d = timeout_q + TimeoutW'(1);
                end
`endif
                // Score is committed on the edge that enters HIT, alongside the rise of correct.
                if (stable_hit) begin
                    score_d  = score_inc;
                    stable_d = '0;
                    state_d  = StHit;
                end else if (timeout_hit) begin
                    hold_d  = '0;
                    state_d = StHold;
                end
            end

            StHit: begin
                hold_d  = '0;
                state_d = StHold;
            end

            StHold: begin
                if (hold_q == HoldLast) begin
                    hold_d  = '0;
                    state_d = (q_index_q == NumQ) ? StDone : StNewQ;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= StIdle;
            lfsr_q    <= LfsrSeed;
            start_q   <= 1'b0;
            op_a_q    <= 7'd0;
            op_b_q    <= 7'd0;
            score_q   <= 7'd0;
            q_index_q <= 7'd0;
            stable_q  <= '0;
            hold_q    <= '0;
`ifdef QUIZ_TIMEOUT_EN
            timeout_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            start_q   <= start_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            score_q   <= score_d;
            q_index_q <= q_index_d;
            stable_q  <= stable_d;
            hold_q    <= hold_d;
`ifdef QUIZ_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign operand_a    = op_a_q;
    assign operand_b    = op_b_q;
    assign score        = score_q;
    assign q_index      = q_index_q;
    assign correct      = (state_q == StHit);
    assign round_active = (state_q == StWait);
    assign game_over    = (state_q == StDone);

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: directed self-checking bench for quiz_round_ctrl.
// Define QUIZ_TIMEOUT_EN for both files to exercise the timeout build.
module tb_quiz_round_ctrl;

    localparam int NumQ    = 99;
    localparam int Stable  = 8;
    localparam int Hold    = 12;
    localparam int Timeout = 50;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic [6:0] answer;
    logic [6:0] operand_a;
    logic [6:0] operand_b;
    logic [6:0] score;
    logic       correct;
    logic       round_active;
    logic       game_over;
    logic [6:0] q_index;

    int checks   = 0;
    int failures = 0;
    int exp_q;
    int exp_score;
    logic [6:0]  exp_a;
    logic [6:0]  exp_b;
    logic [7:0]  exp_sum;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    quiz_round_ctrl #(
        .NUM_QUESTIONS (NumQ),
        .STABLE_CYCLES (Stable),
        .HOLD_CYCLES   (Hold),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .start       (start),
        .answer      (answer),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .score       (score),
        .correct     (correct),
        .round_active(round_active),
        .game_over   (game_over),
        .q_index     (q_index)
    );

    always #5 CLK = ~CLK;

    // Reference LFSR; m_prev is the value the DUT sampled during the previous cycle.
    always @(posedge CLK) begin
        m_prev <= m_lfsr;
        if (RESET === 1'b0) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_question(input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 300 && !ok) begin
            @(negedge CLK);
            n++;
            if (round_active === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_issue: round_active=%b after %0d cycles, required 1", name,
                     round_active, n);
            return;
        end
        exp_q++;
        exp_a   = m_prev[6:0];
        exp_b   = m_prev[14:8];
        exp_sum = {1'b0, exp_a} + {1'b0, exp_b};
        checks++;
        if (q_index !== 7'(exp_q)) begin
            failures++;
            $display("FAIL %s_q_index: got %0d, required %0d", name, q_index, exp_q);
        end
        checks++;
        if (operand_a !== exp_a || operand_b !== exp_b) begin
            failures++;
            $display("FAIL %s_operands: got %0d+%0d, required %0d+%0d", name, operand_a,
                     operand_b, exp_a, exp_b);
        end
        checks++;
        if (({1'b0, operand_a} + {1'b0, operand_b}) > 8'd99) begin
            failures++;
            $display("FAIL %s_sum_range: got %0d+%0d, required sum <= 99", name, operand_a,
                     operand_b);
        end
    endtask

    task automatic answer_and_check(input string name);
        answer = exp_sum[6:0];
        for (int k = 1; k <= Stable; k++) begin
            @(negedge CLK);
            if (k < Stable) begin
                checks++;
                if (correct !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_early: correct=%b at match cycle %0d, required 0", name,
                             correct, k + 1);
                end
            end
        end
        exp_score = (exp_score >= 99) ? 99 : exp_score + 1;
        checks++;
        if (correct !== 1'b1) begin
            failures++;
            $display("FAIL %s_pulse: correct=%b at match cycle %0d, required 1", name, correct,
                     Stable + 1);
        end
        checks++;
        if (score !== 7'(exp_score)) begin
            failures++;
            $display("FAIL %s_score: got %0d, required %0d", name, score, exp_score);
        end
        answer = 7'd100;
    endtask

    task automatic finish_hold(input string name);
        for (int k = 1; k <= Hold + 1; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                checks++;
                if (correct !== 1'b0 || round_active !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_hold_entry: correct=%b round_active=%b, required 0 0",
                             name, correct, round_active);
                end
            end
            if (k == Hold) begin
                checks++;
                if (game_over !== 1'b0 || round_active !== 1'b0 || q_index !== 7'(exp_q)) begin
                    failures++;
                    $display("FAIL %s_hold_end: game_over=%b round_active=%b q_index=%0d, required 0 0 %0d",
                             name, game_over, round_active, q_index, exp_q);
                end
            end
            if (k == Hold + 1) begin
                checks++;
                if (game_over !== (exp_q == NumQ) || round_active !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_hold_exit: game_over=%b round_active=%b, required %0d 0",
                             name, game_over, round_active, exp_q == NumQ);
                end
            end
        end
    endtask

    task automatic run_round(input string name);
        bit ok;
        wait_question(name, ok);
        if (ok) begin
            answer_and_check(name);
            finish_hold(name);
        end
    endtask

    task automatic start_game(input string name);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        checks++;
        if (score !== 7'd0 || q_index !== 7'd0 || game_over !== 1'b0 || round_active !== 1'b0) begin
            failures++;
            $display("FAIL %s_start: score=%0d q_index=%0d game_over=%b round_active=%b, required 0 0 0 0",
                     name, score, q_index, game_over, round_active);
        end
        start     = 1'b0;
        exp_q     = 0;
        exp_score = 0;
    endtask

    task automatic test_reset();
        RESET  = 1'b0;
        start  = 1'b0;
        answer = 7'd100;
        tick(2);
        RESET = 1'b1;
        checks++;
        if (operand_a !== 7'd0 || operand_b !== 7'd0 || score !== 7'd0 || q_index !== 7'd0 ||
            correct !== 1'b0 || round_active !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: a=%0d b=%0d score=%0d q=%0d c=%b ra=%b go=%b, required all 0",
                     operand_a, operand_b, score, q_index, correct, round_active, game_over);
        end
        checks++;
        if (dut.lfsr_q !== 16'hACE1) begin
            failures++;
            $display("FAIL reset_lfsr: got %h, required ace1", dut.lfsr_q);
        end
        tick(5);
        checks++;
        if (round_active !== 1'b0 || q_index !== 7'd0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: round_active=%b q_index=%0d game_over=%b, required 0 0 0",
                     round_active, q_index, game_over);
        end
    endtask

    task automatic test_glitch();
        bit ok;
        wait_question("glitch", ok);
        if (!ok) return;
        answer = exp_sum[6:0];
        for (int k = 1; k <= Stable - 1; k++) begin
            @(negedge CLK);
            checks++;
            if (correct !== 1'b0) begin
                failures++;
                $display("FAIL glitch_pre: correct=%b at cycle %0d, required 0", correct, k + 1);
            end
        end
        answer = 7'd100;
        tick(1);
        answer_and_check("glitch");
        finish_hold("glitch");
    endtask

    task automatic test_timeout();
        bit ok;
        wait_question("timeout", ok);
        if (!ok) return;
        answer = 7'd100;
`ifdef QUIZ_TIMEOUT_EN
        tick(Timeout - 1);
        checks++;
        if (round_active !== 1'b1) begin
            failures++;
            $display("FAIL timeout_wait: round_active=%b in last WAIT cycle, required 1",
                     round_active);
        end
        finish_hold("timeout");
        checks++;
        if (score !== 7'(exp_score)) begin
            failures++;
            $display("FAIL timeout_score: got %0d, required %0d", score, exp_score);
        end
`else
        tick(200);
        checks++;
        if (round_active !== 1'b1 || correct !== 1'b0 || score !== 7'(exp_score)) begin
            failures++;
            $display("FAIL no_timeout: round_active=%b correct=%b score=%0d, required 1 0 %0d",
                     round_active, correct, score, exp_score);
        end
        answer_and_check("no_timeout");
        finish_hold("no_timeout");
`endif
    endtask

    task automatic test_start_ignored();
        bit ok;
        wait_question("start_ignored", ok);
        if (!ok) return;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checks++;
        if (round_active !== 1'b1 || q_index !== 7'(exp_q) || game_over !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored: round_active=%b q_index=%0d game_over=%b, required 1 %0d 0",
                     round_active, q_index, game_over, exp_q);
        end
        answer_and_check("start_ignored");
        finish_hold("start_ignored");
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        wait_question("reset_mid", ok);
        if (!ok) return;
        answer = exp_sum[6:0];
        tick(3);
        RESET = 1'b0;
        tick(1);
        RESET  = 1'b1;
        answer = 7'd100;
        checks++;
        if (operand_a !== 7'd0 || operand_b !== 7'd0 || score !== 7'd0 || q_index !== 7'd0 ||
            correct !== 1'b0 || round_active !== 1'b0 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: a=%0d b=%0d score=%0d q=%0d c=%b ra=%b go=%b, required all 0",
                     operand_a, operand_b, score, q_index, correct, round_active, game_over);
        end
        checks++;
        if (dut.lfsr_q !== 16'hACE1) begin
            failures++;
            $display("FAIL reset_mid_lfsr: got %h, required ace1", dut.lfsr_q);
        end
        tick(4);
        checks++;
        if (round_active !== 1'b0 || q_index !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid_idle: round_active=%b q_index=%0d, required 0 0",
                     round_active, q_index);
        end
    endtask

    task automatic check_game_end(input string name);
        checks++;
        if (game_over !== 1'b1 || score !== 7'd99 || q_index !== 7'd99) begin
            failures++;
            $display("FAIL %s_end: game_over=%b score=%0d q_index=%0d, required 1 99 99", name,
                     game_over, score, q_index);
        end
    endtask

    task automatic test_full_game();
        start_game("full");
        for (int i = 0; i < NumQ; i++) run_round("full");
        check_game_end("full");
        tick(50);
        checks++;
        if (game_over !== 1'b1 || q_index !== 7'd99 || score !== 7'd99 ||
            operand_a !== exp_a || operand_b !== exp_b) begin
            failures++;
            $display("FAIL full_done_hold: go=%b q=%0d score=%0d a=%0d b=%0d, required 1 99 99 %0d %0d",
                     game_over, q_index, score, operand_a, operand_b, exp_a, exp_b);
        end
    endtask

    task automatic test_back_to_back();
        for (int g = 0; g < 10; g++) begin
            start_game("b2b");
            for (int i = 0; i < NumQ; i++) run_round("b2b");
            check_game_end("b2b");
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_q     = 0;
        exp_score = 0;
        test_reset();
        start_game("first");
        run_round("correct_answer");
        test_glitch();
        test_timeout();
        test_start_ignored();
        test_reset_mid_wait();
        test_full_game();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
